// File: rtl/my_gates_pkg.sv
// Shared definitions for the two-operand primitive gate block: the gate
// selector type and the reset value of the registered results.
package my_gates_pkg;

    // Selects which bitwise function a my_gate2 instance implements.
    typedef enum logic [1:0] {
        OP_NAND,
        OP_NOR,
        OP_XNOR
    } gate_op_e;

    // Result registers reset to all ones: the value every gate produces for
    // zero operands, so a reset output looks like a valid 0/0 evaluation.
    localparam logic RESULT_RST_BIT = 1'b1;

endpackage

// File: rtl/my_gate2.sv
// WIDTH-wide bitwise two-input gate; the function is fixed at elaboration
// by the op parameter so each instance is a plain gate array.
import my_gates_pkg::*;

module my_gate2 #(
    parameter int       WIDTH = 1,
    parameter gate_op_e OP    = OP_NAND
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    generate
        if (OP == OP_NAND) begin : g_nand
            assign y = ~(a & b);
        end else if (OP == OP_NOR) begin : g_nor
            assign y = ~(a | b);
        end else begin : g_xnor
            assign y = ~(a ^ b);
        end
    endgenerate

endmodule

// File: rtl/my_nand_nor_xnor.sv
// Bitwise NAND/NOR/XNOR unit. Combinational results are always available;
// the _q outputs are either a one-cycle registered copy captured on
// in_valid (REG_OUT=1) or a straight pass-through (REG_OUT=0).
import my_gates_pkg::*;

module my_nand_nor_xnor #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] nand_c,
    output logic [WIDTH-1:0] nor_c,
    output logic [WIDTH-1:0] xnor_c,
    output logic [WIDTH-1:0] nand_q,
    output logic [WIDTH-1:0] nor_q,
    output logic [WIDTH-1:0] xnor_q,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] RESULT_RST = {WIDTH{RESULT_RST_BIT}};

    my_gate2 #(.WIDTH(WIDTH), .OP(OP_NAND)) u_nand (
        .a (in1),
        .b (in2),
        .y (nand_c)
    );

    my_gate2 #(.WIDTH(WIDTH), .OP(OP_NOR)) u_nor (
        .a (in1),
        .b (in2),
        .y (nor_c)
    );

    my_gate2 #(.WIDTH(WIDTH), .OP(OP_XNOR)) u_xnor (
        .a (in1),
        .b (in2),
        .y (xnor_c)
    );

    generate
        if (REG_OUT) begin : g_reg
            // Capture results only when operands are valid; hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nand_q <= RESULT_RST;
                    nor_q  <= RESULT_RST;
                    xnor_q <= RESULT_RST;
                end else if (in_valid) begin
                    nand_q <= nand_c;
                    nor_q  <= nor_c;
                    xnor_q <= xnor_c;
                end
            end

            // The valid flag follows in_valid by one cycle, every cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                end
            end
        end else begin : g_comb
            assign nand_q    = nand_c;
            assign nor_q     = nor_c;
            assign xnor_q    = xnor_c;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_my_nand_nor_xnor.sv
// Bench for my_nand_nor_xnor: directed 1-bit truth table, reset and hold,
// 8-bit pattern with both REG_OUT settings, exhaustive 4-bit sweep and a
// short random 8-bit run with random valid.
module tb_my_nand_nor_xnor;

    logic clk;
    logic rst_n;

    // WIDTH=1, registered
    logic       a1, b1, v1;
    logic       nand_c1, nor_c1, xnor_c1, nand_q1, nor_q1, xnor_q1, ov1;
    // WIDTH=4, registered
    logic [3:0] a4, b4;
    logic       v4;
    logic [3:0] nand_c4, nor_c4, xnor_c4, nand_q4, nor_q4, xnor_q4;
    logic       ov4;
    // WIDTH=8, registered and pass-through instances share operands
    logic [7:0] a8, b8;
    logic       v8;
    logic [7:0] nand_c8, nor_c8, xnor_c8, nand_q8, nor_q8, xnor_q8;
    logic       ov8;
    logic [7:0] nand_cp, nor_cp, xnor_cp, nand_qp, nor_qp, xnor_qp;
    logic       ovp;

    int errors = 0;
    int checks = 0;

    // Scoreboards: {nand, nor, xnor, valid} expected after the next edge
    logic [3:0]  exp1_q[$];
    logic [12:0] exp4_q[$];
    logic [24:0] exp8_q[$];
    // Model of the held register contents
    logic [2:0]  m1;
    logic [11:0] m4;
    logic [23:0] m8;

    my_nand_nor_xnor #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in1(a1), .in2(b1), .in_valid(v1),
        .nand_c(nand_c1), .nor_c(nor_c1), .xnor_c(xnor_c1),
        .nand_q(nand_q1), .nor_q(nor_q1), .xnor_q(xnor_q1), .out_valid(ov1)
    );

    my_nand_nor_xnor #(.WIDTH(4), .REG_OUT(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .in1(a4), .in2(b4), .in_valid(v4),
        .nand_c(nand_c4), .nor_c(nor_c4), .xnor_c(xnor_c4),
        .nand_q(nand_q4), .nor_q(nor_q4), .xnor_q(xnor_q4), .out_valid(ov4)
    );

    my_nand_nor_xnor #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n), .in1(a8), .in2(b8), .in_valid(v8),
        .nand_c(nand_c8), .nor_c(nor_c8), .xnor_c(xnor_c8),
        .nand_q(nand_q8), .nor_q(nor_q8), .xnor_q(xnor_q8), .out_valid(ov8)
    );

    my_nand_nor_xnor #(.WIDTH(8), .REG_OUT(1'b0)) u8p (
        .clk(clk), .rst_n(rst_n), .in1(a8), .in2(b8), .in_valid(v8),
        .nand_c(nand_cp), .nor_c(nor_cp), .xnor_c(xnor_cp),
        .nand_q(nand_qp), .nor_q(nor_qp), .xnor_q(xnor_qp), .out_valid(ovp)
    );

    // Clock: 20 time units per cycle, rising edges at 10, 30, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference built from the per-bit truth table: returns {nand, nor, xnor}
    function automatic logic [23:0] ref8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] nd, nr, xn;
        for (int i = 0; i < 8; i++) begin
            case ({a[i], b[i]})
                2'b00:   {nd[i], nr[i], xn[i]} = 3'b111;
                2'b01:   {nd[i], nr[i], xn[i]} = 3'b100;
                2'b10:   {nd[i], nr[i], xn[i]} = 3'b100;
                default: {nd[i], nr[i], xn[i]} = 3'b001;
            endcase
        end
        return {nd, nr, xn};
    endfunction

    function automatic logic [11:0] ref4(input logic [3:0] a, input logic [3:0] b);
        logic [23:0] r;
        r = ref8({4'h0, a}, {4'h0, b});
        return {r[19:16], r[11:8], r[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_models();
        m1 = 3'b111;
        m4 = '1;
        m8 = '1;
    endtask

    // One 1-bit cycle: exp_c is the table value for this operand pair
    task automatic step1(input logic a, input logic b, input logic v, input logic [2:0] exp_c);
        logic [3:0] e;
        @(negedge clk);
        a1 = a; b1 = b; v1 = v;
        if (v) m1 = exp_c;
        exp1_q.push_back({m1, v});
        #1;
        check("u1_comb", 32'({nand_c1, nor_c1, xnor_c1}), 32'(exp_c));
        @(posedge clk);
        #1;
        if (exp1_q.size() == 0) begin
            check("u1_q_empty", 32'(1), 32'(0));
        end else begin
            e = exp1_q.pop_front();
            check("u1_q", 32'({nand_q1, nor_q1, xnor_q1, ov1}), 32'(e));
        end
    endtask

    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic v);
        logic [11:0] r;
        logic [12:0] e;
        @(negedge clk);
        a4 = a; b4 = b; v4 = v;
        r = ref4(a, b);
        if (v) m4 = r;
        exp4_q.push_back({m4, v});
        #1;
        check("u4_comb", 32'({nand_c4, nor_c4, xnor_c4}), 32'(r));
        @(posedge clk);
        #1;
        if (exp4_q.size() == 0) begin
            check("u4_q_empty", 32'(1), 32'(0));
        end else begin
            e = exp4_q.pop_front();
            check("u4_q", 32'({nand_q4, nor_q4, xnor_q4, ov4}), 32'(e));
        end
    endtask

    task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic v);
        logic [23:0] r;
        logic [24:0] e;
        @(negedge clk);
        a8 = a; b8 = b; v8 = v;
        r = ref8(a, b);
        if (v) m8 = r;
        exp8_q.push_back({m8, v});
        #1;
        check("u8_comb", 32'({nand_c8, nor_c8, xnor_c8}), 32'(r));
        check("u8p_q_same_cycle", 32'({nand_qp, nor_qp, xnor_qp}), 32'(r));
        check("u8p_valid", 32'(ovp), 32'(v));
        @(posedge clk);
        #1;
        if (exp8_q.size() == 0) begin
            check("u8_q_empty", 32'(1), 32'(0));
        end else begin
            e = exp8_q.pop_front();
            check("u8_q", 32'({nand_q8, nor_q8, xnor_q8, ov8}), 32'(e));
        end
    endtask

    initial begin
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        a4 = '0;   b4 = '0;   v4 = 1'b0;
        a8 = '0;   b8 = '0;   v8 = 1'b0;
        reset_models();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #4;
        check("reset_u1_q", 32'({nand_q1, nor_q1, xnor_q1}), 32'(3'b111));
        check("reset_u1_valid", 32'(ov1), 32'(0));
        check("reset_u8_q", 32'({nand_q8, nor_q8, xnor_q8}), 32'hFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;

        // 1-bit truth table, each pair held one 20-unit cycle
        step1(1'b0, 1'b0, 1'b1, 3'b111);
        step1(1'b0, 1'b1, 1'b1, 3'b100);
        step1(1'b1, 1'b1, 1'b1, 3'b001);
        step1(1'b1, 1'b0, 1'b1, 3'b100);

        // Reset between edges while a capture is pending
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        #5 rst_n = 1'b0;
        #1;
        check("midreset_u1_q", 32'({nand_q1, nor_q1, xnor_q1}), 32'(3'b111));
        check("midreset_u1_valid", 32'(ov1), 32'(0));
        reset_models();
        @(negedge clk);
        rst_n = 1'b1;
        step1(1'b1, 1'b1, 1'b1, 3'b001);

        // Hold: capture 0/1 then three idle cycles with 1/1 on the inputs
        step1(1'b0, 1'b1, 1'b1, 3'b100);
        for (int i = 0; i < 3; i++) step1(1'b1, 1'b1, 1'b0, 3'b001);

        // 8-bit directed pattern with explicit constants
        step8(8'hF0, 8'hCC, 1'b1);
        check("u8_F0_CC_q", 32'({nand_q8, nor_q8, xnor_q8}), 32'h3F03C3);
        check("u8p_F0_CC_c", 32'({nand_cp, nor_cp, xnor_cp}), 32'h3F03C3);
        step8(8'h00, 8'h00, 1'b0);
        check("u8_hold_F0_CC", 32'({nand_q8, nor_q8, xnor_q8}), 32'h3F03C3);

        // Random 8-bit operands with random valid
        for (int i = 0; i < 24; i++) begin
            step8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step4(4'(a), 4'(b), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
